// File: rtl/ex_s2p.sv
// Serial-to-parallel frame receiver: hunts for a 4-bit preamble, then shifts in
// {rnw, addr, data, crc} and presents the decoded fields with CRC/fill checks.
module ex_s2p #(
  parameter logic [3:0] PREAMBLE  = 4'hA,
  parameter logic [7:0] RD_FILL   = 8'h5A,
  parameter int         ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sdata,
  input  logic                 err_clr,
  output logic                 valid,
  output logic                 rnw,
  output logic [7:0]           addr,
  output logic [7:0]           data,
  output logic                 crc_err,
  output logic                 fill_err,
  output logic                 in_frame,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic {HUNT, RECV} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  window;
  logic [20:0] shreg;
  logic [4:0]  bit_cnt;
  logic [20:0] frame_next;
  logic        last_bit;
  logic        crc_bad;
  logic        err_evt;

  function automatic logic [3:0] crc_calc(input logic [16:0] d);
    logic [3:0] c;
    c[0] = ~(d[15] ^ d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[0]);
    c[1] = d[16] ^ d[15] ^ d[12] ^ d[8] ^ d[7] ^ d[6] ^ d[5] ^ d[3] ^ d[1] ^ d[0];
    c[2] = d[16] ^ d[13] ^ d[9] ^ d[8] ^ d[7] ^ d[6] ^ d[4] ^ d[2] ^ d[1];
    c[3] = ~(d[14] ^ d[10] ^ d[9] ^ d[8] ^ d[7] ^ d[5] ^ d[3] ^ d[2]);
    return c;
  endfunction

  // frame_next holds the complete 21-bit body on the edge that samples the last CRC bit
  assign frame_next = {shreg[19:0], sdata};
  assign last_bit   = (state == RECV) && (bit_cnt == 5'd20);
  assign crc_bad    = (frame_next[3:0] != crc_calc(frame_next[20:4]));
  assign err_evt    = last_bit && crc_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HUNT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT: if ({window[2:0], sdata} == PREAMBLE) state_next = RECV;
      RECV: if (bit_cnt == 5'd20) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window   <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      valid    <= 1'b0;
      rnw      <= 1'b0;
      addr     <= '0;
      data     <= '0;
      crc_err  <= 1'b0;
      fill_err <= 1'b0;
      in_frame <= 1'b0;
    end else begin
      valid    <= 1'b0;
      in_frame <= (state_next == RECV);
      if (state == HUNT) begin
        window  <= {window[2:0], sdata};
        bit_cnt <= '0;
      end else begin
        shreg   <= frame_next;
        bit_cnt <= bit_cnt + 5'd1;
        if (last_bit) begin
          valid    <= 1'b1;
          rnw      <= frame_next[20];
          addr     <= frame_next[19:12];
          data     <= frame_next[11:4];
          crc_err  <= crc_bad;
          fill_err <= frame_next[20] && (frame_next[11:4] != RD_FILL);
          window   <= '0;
        end
      end
    end
  end

  // A clear that lands on the same edge as a counted error leaves exactly that one error
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt <= '0;
    else if (err_clr)
      err_cnt <= {{(ERR_CNT_W-1){1'b0}}, err_evt};
    else if (err_evt && (err_cnt != {ERR_CNT_W{1'b1}}))
      err_cnt <= err_cnt + ERR_CNT_W'(1);
  end

endmodule

// File: tb/tb_ex_s2p.sv
// Bench for ex_s2p: frames are generated as whole transactions, expected results
// are scheduled by arrival cycle and checked every cycle against the DUT outputs.
module tb_ex_s2p;

  localparam logic [3:0] PRE  = 4'hA;
  localparam logic [7:0] FILL = 8'h5A;
  localparam int         MAXC = 32768;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sdata = 1'b0;
  logic       err_clr = 1'b0;
  logic       valid, rnw, crc_err, fill_err, in_frame;
  logic [7:0] addr, data, err_cnt;

  ex_s2p #(.PREAMBLE(PRE), .RD_FILL(FILL), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sdata(sdata), .err_clr(err_clr),
    .valid(valid), .rnw(rnw), .addr(addr), .data(data),
    .crc_err(crc_err), .fill_err(fill_err), .in_frame(in_frame), .err_cnt(err_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  typedef struct {
    int         due;
    logic       rnw;
    logic [7:0] addr;
    logic [7:0] data;
    logic       crc_err;
    logic       fill_err;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_in[MAXC];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] crc4(input logic [16:0] d);
    logic [3:0] c;
    c[0] = ~(d[15] ^ d[11] ^ d[10] ^ d[9] ^ d[8] ^ d[6] ^ d[4] ^ d[3] ^ d[0]);
    c[1] = d[16] ^ d[15] ^ d[12] ^ d[8] ^ d[7] ^ d[6] ^ d[5] ^ d[3] ^ d[1] ^ d[0];
    c[2] = d[16] ^ d[13] ^ d[9] ^ d[8] ^ d[7] ^ d[6] ^ d[4] ^ d[2] ^ d[1];
    c[3] = ~(d[14] ^ d[10] ^ d[9] ^ d[8] ^ d[7] ^ d[5] ^ d[3] ^ d[2]);
    return c;
  endfunction

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sdata   = 1'b0;
      err_clr = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    sdata   = 1'b0;
    err_clr = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst     = 1'b1;
    sdata   = 1'b0;
    err_clr = 1'b0;
    @(posedge clk); #1;
    rst     = 1'b0;
  endtask

  // Sends nbits of a frame; bit i is sampled on edge n+i where n is the first-bit edge.
  task automatic send_frame(input logic r, input logic [7:0] a, input logic [7:0] dt,
                            input logic [3:0] c, input int nbits, input bit clr_last);
    logic [24:0] bits;
    int          n;
    int          last_in;
    exp_t        e;
    bits = {PRE, r, a, dt, c};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        n       = cyc + 1;
        last_in = (nbits == 25) ? n + 23 : n + nbits - 2;
        for (int k = n + 3; k <= last_in; k++)
          if (k < MAXC) exp_in[k] = 1'b1;
        if (nbits == 25) begin
          e.due      = n + 24;
          e.rnw      = r;
          e.addr     = a;
          e.data     = dt;
          e.crc_err  = (c != crc4({r, a, dt}));
          e.fill_err = r && (dt != FILL);
          exp_q.push_back(e);
        end
      end
      sdata   = bits[24 - i];
      err_clr = clr_last && (i == 24);
    end
  endtask

  // compare process
  exp_t       h = '{0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
  exp_t       cur;
  logic       prev_clr = 1'b0;
  logic [7:0] exp_err = 8'h00;
  logic       ev;

  always @(negedge clk) begin
    if (rst) begin
      exp_err = 8'h00;
      h       = '{0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      check("rst_valid", valid, 1'b0);
      check("rst_in_frame", in_frame, 1'b0);
      check("rst_err_cnt", err_cnt, 8'h00);
      check("rst_fields", {rnw, addr, data, crc_err, fill_err}, 19'h0);
    end else begin
      ev = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        cur = exp_q.pop_front();
        check("valid_pulse", valid, 1'b1);
        h  = cur;
        ev = cur.crc_err;
      end else begin
        check("valid_idle", valid, 1'b0);
      end
      check("fields", {rnw, addr, data, crc_err, fill_err},
            {h.rnw, h.addr, h.data, h.crc_err, h.fill_err});
      if (prev_clr)                   exp_err = ev ? 8'h01 : 8'h00;
      else if (ev && exp_err != 8'hFF) exp_err = exp_err + 8'h01;
      check("err_cnt", err_cnt, exp_err);
      check("in_frame", in_frame, (cyc < MAXC) ? exp_in[cyc] : 1'b0);
    end
    prev_clr = err_clr;
  end

  // stimulus
  logic       r_r;
  logic [7:0] r_a, r_d;
  logic [3:0] r_c;
  bit         r_clr;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // model pins against hand-computed CRCs
    check("crc_pin_write", crc4(17'h03CA5), 4'hC);
    check("crc_pin_read", crc4(17'h1005A), 4'h0);

    send_frame(1'b0, 8'h3C, 8'hA5, 4'hC, 25, 1'b0); idle(2);
    send_frame(1'b1, 8'h00, 8'h5A, 4'h0, 25, 1'b0); idle(2);

    send_frame(1'b0, 8'h3C, 8'hA5, 4'hD, 25, 1'b0); idle(2);
    @(negedge clk); check("err_cnt_after_bad", err_cnt, 8'h01);
    pulse_clr(); idle(1);
    @(negedge clk); check("err_cnt_after_clr", err_cnt, 8'h00);

    // back-to-back, no idle bit
    send_frame(1'b0, 8'h3C, 8'hA5, 4'hC, 25, 1'b0);
    send_frame(1'b1, 8'h00, 8'h5A, 4'h0, 25, 1'b0);
    idle(2);

    // reset while bit 12 is on the line, then a clean frame
    send_frame(1'b0, 8'h3C, 8'hA5, 4'hC, 13, 1'b0);
    do_reset();
    send_frame(1'b0, 8'h3C, 8'hA5, 4'hC, 25, 1'b0); idle(2);

    // read frame with wrong fill but good CRC
    send_frame(1'b1, 8'h00, 8'h00, crc4(17'h10000), 25, 1'b0); idle(2);
    @(negedge clk); check("fill_err_literal", {fill_err, crc_err}, 2'b10);

    // randomized frames, including err_clr coinciding with frame ends
    for (int i = 0; i < 150; i++) begin
      r_r   = 1'($urandom_range(0, 1));
      r_a   = 8'($urandom);
      r_d   = ($urandom_range(0, 3) == 0) ? FILL : 8'($urandom);
      r_c   = crc4({r_r, r_a, r_d});
      if ($urandom_range(0, 9) >= 7) r_c = r_c ^ 4'($urandom_range(1, 15));
      r_clr = ($urandom_range(0, 5) == 0);
      send_frame(r_r, r_a, r_d, r_c, 25, r_clr);
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin pulse_clr(); idle(1); end
    end

    // saturation: 256 corrupted frames back-to-back
    for (int i = 0; i < 256; i++) begin
      r_a = 8'($urandom);
      r_d = 8'($urandom);
      send_frame(1'b0, r_a, r_d, ~crc4({1'b0, r_a, r_d}), 25, 1'b0);
    end
    idle(2);
    @(negedge clk); check("err_cnt_saturated", err_cnt, 8'hFF);

    idle(30);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_s2p.md
EX_S2P -- requirements
Module: ex_s2p

Interface
REQ-001 Parameter PREAMBLE, default 4'hA: 4-bit frame start pattern, MSB first.
REQ-002 Parameter RD_FILL, default 8'h5A: data field value required in read frames.
REQ-003 Parameter ERR_CNT_W, default 8: width of the CRC error counter.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 sdata  input  1  serial frame input, MSB first, idles 0.
REQ-008 err_clr  input  1  synchronous clear of err_cnt.
REQ-009 valid  output  1  one-cycle pulse: frame fields are valid.
REQ-010 rnw  output  1  received read/not-write bit.
REQ-011 addr  output  8  received address.
REQ-012 data  output  8  received data field.
REQ-013 crc_err  output  1  CRC mismatch for the frame flagged by valid.
REQ-014 fill_err  output  1  rnw=1 and data != RD_FILL, for the frame flagged by valid.
REQ-015 in_frame  output  1  high while the block is in the RECV state.
REQ-016 err_cnt  output  ERR_CNT_W  count of CRC-failed frames, saturating.

Function
REQ-017 Frame SHALL be 25 bits, one bit per clk: PREAMBLE[3:0], rnw, addr[7:0], data[7:0], crc[3:0], each field MSB first.
REQ-018 The FSM SHALL have two states: HUNT and RECV; every output SHALL be registered.
REQ-019 In HUNT, a 4-bit window SHALL shift in sdata each cycle; when {window[2:0], sdata} == PREAMBLE, next state SHALL be RECV with bit counter = 0.
REQ-020 In RECV, each cycle SHALL shift sdata into a 21-bit register and increment a 5-bit counter; the counter value 20 marks the last CRC bit.
REQ-021 On the edge sampling the last CRC bit, the block SHALL: load rnw/addr/data, crc_err and fill_err; set valid=1; return to HUNT with the window cleared to 0.
REQ-022 valid SHALL be high for exactly one cycle per frame; rnw/addr/data/crc_err/fill_err SHALL hold until the next valid.
REQ-023 Latency: if the first preamble bit is sampled at edge N, valid SHALL rise at edge N+24.
REQ-024 Back-to-back frames with no idle bit SHALL all be received, giving one valid every 25 cycles.
REQ-025 Bit patterns equal to PREAMBLE inside RECV SHALL be treated as payload and SHALL NOT restart the frame.
REQ-026 Let d[16:0] = {rnw, addr, data}; expected CRC (init 4'hF folded in) SHALL be:
  c0 = ~(d15^d11^d10^d9^d8^d6^d4^d3^d0)
  c1 = d16^d15^d12^d8^d7^d6^d5^d3^d1^d0
  c2 = d16^d13^d9^d8^d7^d6^d4^d2^d1
  c3 = ~(d14^d10^d9^d8^d7^d5^d3^d2)
REQ-027 crc_err SHALL be 1 when the received crc[3:0] != {c3,c2,c1,c0}.
REQ-028 err_cnt SHALL increment on valid with crc_err=1 and saturate at all-ones.
REQ-029 err_clr SHALL force err_cnt to 0; if err_clr coincides with a counted error, err_cnt SHALL be 1.
REQ-030 in_frame SHALL be 1 exactly while the state is RECV.

Reset
REQ-031 rst SHALL immediately force: HUNT state, window 0, counter 0, valid 0, rnw 0, addr 0, data 0, crc_err 0, fill_err 0, in_frame 0, err_cnt 0.
REQ-032 rst asserted mid-frame SHALL discard the partial frame with no valid pulse; reception SHALL resume with the next full preamble after rst deasserts.

Verification
REQ-033 Write frame A,0,3C,A5,C -> valid 1 cycle at N+24; rnw=0, addr=3C, data=A5, crc_err=0, fill_err=0.
REQ-034 Read frame A,1,00,5A,0 -> rnw=1, addr=00, data=5A, crc_err=0, fill_err=0.
REQ-035 Write frame A,0,3C,A5,D (corrupted CRC) -> crc_err=1, err_cnt 0->1; then err_clr=1 for 1 cycle -> err_cnt=0.
REQ-036 Both frames above sent back-to-back, no gap -> two valid pulses 25 cycles apart, each with correct fields.
REQ-037 rst pulse at bit 12 of a frame, followed by a clean frame -> no valid for the aborted frame, one correct valid for the clean one.
REQ-038 Read frame A,1,00,00 with correct CRC for that payload -> fill_err=1, crc_err=0; 256 corrupted frames -> err_cnt stays FF.
